// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types and default widths for the initiator and the 4-register slave.
package axi4_lite_pkg;

  localparam int AXI_ADDR_WIDTH = 4;
  localparam int AXI_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } mst_state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns a start/write/addr/data command into
// AW/W/B or AR/R handshakes, with an optional watchdog that aborts a stuck transfer.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int TIMEOUT    = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_start,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  cmd_ready,
  output logic                  cmd_done,
  output logic [DATA_WIDTH-1:0] cmd_rdata,
  output logic [1:0]            cmd_resp,
  output logic                  cmd_timeout,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [1:0]            RRESP
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  mst_state_e            r_state,   w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,    w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,   w_wdata_nxt;
  logic [DATA_WIDTH-1:0] r_rdata,   w_rdata_nxt;
  logic [1:0]            r_resp,    w_resp_nxt;
  logic [CNT_W-1:0]      r_cnt,     w_cnt_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid,  w_wvalid_nxt;
  logic                  r_bready,  w_bready_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic                  r_rready,  w_rready_nxt;
  logic                  r_aw_done, w_aw_done_nxt;
  logic                  r_w_done,  w_w_done_nxt;
  logic                  r_done,    w_done_nxt;
  logic                  r_timeout, w_timeout_nxt;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_expired;

  assign w_aw_hs   = r_awvalid & AWREADY;
  assign w_w_hs    = r_wvalid & WREADY;
  assign w_expired = (TIMEOUT != 0) && (r_state != ST_IDLE) && (r_cnt == CNT_LAST);

  // Next-state and next-output logic; every output is taken from a register below.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_rdata_nxt   = r_rdata;
    w_resp_nxt    = r_resp;
    w_cnt_nxt     = r_cnt;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_bready_nxt  = r_bready;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_done_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (cmd_start) begin
          w_addr_nxt = cmd_addr;
          if (cmd_write) begin
            w_wdata_nxt   = cmd_wdata;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
            w_state_nxt   = ST_WR_REQ;
          end else begin
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = ST_RD_REQ;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // AW and W complete independently; BREADY waits for whichever finishes last.
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end else begin
          w_aw_done_nxt = r_aw_done;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end else begin
          w_w_done_nxt = r_w_done;
        end
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = ST_WR_RESP;
        end else begin
          w_state_nxt = ST_WR_REQ;
        end
      end
      ST_WR_RESP: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (BVALID & r_bready) begin
          w_bready_nxt = 1'b0;
          w_resp_nxt   = BRESP;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt = ST_WR_RESP;
        end
      end
      ST_RD_REQ: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_arvalid & ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = ST_RD_RESP;
        end else begin
          w_state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_RESP: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (RVALID & r_rready) begin
          w_rready_nxt = 1'b0;
          w_rdata_nxt  = RDATA;
          w_resp_nxt   = RRESP;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt = ST_RD_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // The watchdog outranks any handshake landing on the same edge.
    if (w_expired) begin
      w_awvalid_nxt = 1'b0;
      w_wvalid_nxt  = 1'b0;
      w_bready_nxt  = 1'b0;
      w_arvalid_nxt = 1'b0;
      w_rready_nxt  = 1'b0;
      w_resp_nxt    = SLVERR;
      w_timeout_nxt = 1'b1;
      w_done_nxt    = 1'b1;
      w_cnt_nxt     = '0;
      w_state_nxt   = ST_IDLE;
    end else begin
      w_timeout_nxt = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_resp    <= 2'b00;
      r_cnt     <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rdata   <= w_rdata_nxt;
      r_resp    <= w_resp_nxt;
      r_cnt     <= w_cnt_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign cmd_done    = r_done;
  assign cmd_rdata   = r_rdata;
  assign cmd_resp    = r_resp;
  assign cmd_timeout = r_timeout;
  assign AWADDR      = r_addr;
  assign ARADDR      = r_addr;
  assign AWVALID     = r_awvalid;
  assign WDATA       = r_wdata;
  assign WVALID      = r_wvalid;
  assign BREADY      = r_bready;
  assign ARVALID     = r_arvalid;
  assign RREADY      = r_rready;

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator. It converts a simple command interface (start pulse, read/write select, address, data) into AXI4-Lite AW/W/B or AR/R handshakes.
- It is the initiator-side counterpart to the team's 4-register AXI4-Lite slave, and drives it from a CPU-side or test controller.
- It returns read data, the response code and a one-cycle done pulse per transfer.

Parameters:
- ADDR_WIDTH, 4, width of AWADDR/ARADDR and cmd_addr.
- DATA_WIDTH, 32, width of WDATA/RDATA, cmd_wdata and cmd_rdata.
- TIMEOUT, 256, cycles allowed from command accept to completion. 0 disables the timeout.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_start  in  1  command request, sampled only while cmd_ready=1.
- cmd_write  in  1  1=write, 0=read; sampled with cmd_start.
- cmd_addr  in  ADDR_WIDTH  byte address; sampled with cmd_start.
- cmd_wdata  in  DATA_WIDTH  write data; sampled with cmd_start.
- cmd_ready  out  1  high in IDLE.
- cmd_done  out  1  one-cycle completion pulse.
- cmd_rdata  out  DATA_WIDTH  read data; held until the next read completes.
- cmd_resp  out  2  BRESP/RRESP of the last transfer, or 2'b10 on timeout.
- cmd_timeout  out  1  high together with cmd_done when a transfer aborted.
- AWADDR out ADDR_WIDTH; AWVALID out 1; AWREADY in 1.
- WDATA out DATA_WIDTH; WVALID out 1; WREADY in 1.
- BRESP in 2; BVALID in 1; BREADY out 1.
- ARADDR out ADDR_WIDTH; ARVALID out 1; ARREADY in 1.
- RDATA in DATA_WIDTH; RVALID in 1; RREADY out 1; RRESP in 2.

Behaviour:
- Interface decision: one clock (ACLK). Reset ARESET is synchronous and active-high.
- Reset values:
  - State=IDLE.
  - All VALID/READY outputs 0; cmd_done=0; cmd_timeout=0.
  - cmd_resp=0; cmd_rdata=0; AWADDR/ARADDR/WDATA=0.
  - Timeout counter=0.
- Reset mid-transfer: on the clock edge where ARESET=1, all outputs return to reset values regardless of state.
- All AXI outputs are registered; no combinational path from AXI inputs to AXI outputs.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - cmd_ready=1.
  - cmd_start&cmd_write: latch addr/data, set AWVALID=WVALID=1 next cycle, go to WR_REQ.
  - cmd_start&!cmd_write: latch addr, set ARVALID=1 next cycle, go to RD_REQ.
- WR_REQ: AW and W are tracked independently with flags aw_done/w_done.
  - AWVALID drops the cycle after AWVALID&AWREADY is sampled; likewise WVALID after WVALID&WREADY.
  - Both handshakes may occur in the same cycle, or in either order with any gap.
  - When both are done, assert BREADY and go to WR_RESP.
  - AWADDR/WDATA are stable while their VALID is high.
- WR_RESP: on BVALID&BREADY, drop BREADY, capture BRESP into cmd_resp, pulse cmd_done next cycle, return to IDLE.
- RD_REQ: on ARVALID&ARREADY, drop ARVALID, assert RREADY, go to RD_RESP.
- RD_RESP: on RVALID&RREADY, capture RDATA→cmd_rdata and RRESP→cmd_resp, drop RREADY, pulse cmd_done, return to IDLE.
- cmd_done and cmd_ready are both high in the first IDLE cycle. A new cmd_start in that cycle is accepted, so the back-to-back command period is 1 cycle plus handshake latency.
- VALID, once asserted, is never deasserted before its handshake except via timeout or reset. VALID never waits for READY.
- Early readiness: the slave may hold READY high before VALID. A handshake then completes in the first VALID cycle, giving minimum latency.
- Minimum write latency (cmd_start to cmd_done): 4 cycles with zero-wait slave. Minimum read latency: 4 cycles.
- Timeout (TIMEOUT>0):
  - The counter clears on accept and increments every non-IDLE cycle.
  - On reaching TIMEOUT, all VALID/READY drop, cmd_resp=2'b10, cmd_timeout=1, cmd_done pulses, state=IDLE.
  - This is a recovery path only; the interconnect must be reset afterwards.
- cmd_start while cmd_ready=0 is ignored; no queueing.
- Address is passed through unaligned; no bit masking. The slave decodes ADDR[3:2].

Decomposition:
- Package axi4_lite_pkg holds:
  - resp_e: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - mst_state_e.
  - Default ADDR_WIDTH/DATA_WIDTH constants.
- The slave also imports the package.
- No sub-module; one FSM plus the timeout counter in a single module.

Test Plan:
- Write 0xDEADBEEF to 0x4; slave AWREADY after 1 cycle, WREADY after 3 → AW and W handshake once each, BREADY after both. cmd_done after BVALID; cmd_resp=00; slave reg1=0xDEADBEEF.
- Read 0x4 after that write; ARREADY after 2, RVALID after 1, RRESP=00 → cmd_rdata=0xDEADBEEF, cmd_done pulse exactly one cycle.
- Slave holds WREADY/AWREADY high before VALID → both handshake in the first VALID cycle, cmd_done 4 cycles after cmd_start.
- Back-to-back: writes 0x11111111@0x0 and 0x22222222@0xC, then reads of 0x0 and 0xC, each cmd_start on the cmd_done cycle → reads return 0x11111111 then 0x22222222, no dropped command.
- Assert ARESET while in WR_RESP with BVALID withheld → next cycle all outputs at reset values, cmd_ready=1; a subsequent read of 0x8 completes normally.
- TIMEOUT=16, slave never asserts ARREADY → ARVALID high for 16 cycles, then dropped. cmd_done=1, cmd_timeout=1, cmd_resp=2'b10.
